// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit over a byte-enabled synchronous-read data RAM.
// Loads stall the core for two cycles while the registered RAM word is lane-selected and extended.
module dmem_lsu #(
    parameter int ADDR_W    = 10,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] address_DMEM,
    input  logic [31:0]       write_data_DMEM,
    input  logic [2:0]        funct3,
    output logic [31:0]       data_DMEM,
    output logic              stall,
    output logic              access_fault
);
    localparam int DEPTH = 1 << (ADDR_W - 2);
    localparam logic [31:0] INIT_WORD = INIT_ZERO ? 32'h0 : 32'hx;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;

    state_t            state;
    logic [31:0]       mem [DEPTH] = '{default: INIT_WORD};
    logic [31:0]       ram_q;
    logic [2:0]        f3_q;
    logic [1:0]        lane_q;
    logic [ADDR_W-3:0] idx;
    logic [1:0]        lane;
    logic              idle, aligned, legal_ld, legal_st, fault, do_st, do_ld;
    logic [3:0]        be;
    logic [31:0]       wdata, ext;
    logic [7:0]        rb;
    logic [15:0]       rh;

    always_comb begin
        idx          = address_DMEM[ADDR_W-1:2];
        lane         = address_DMEM[1:0];
        idle         = state == IDLE;
        aligned      = funct3[1:0] == 2'b00 || (funct3[1:0] == 2'b01 && !lane[0]) ||
                       (funct3[1:0] == 2'b10 && lane == 2'b00);
        legal_st     = aligned && !funct3[2];
        legal_ld     = aligned && funct3 != 3'b110;
        fault        = idle && (MemWrite ? !legal_st : MemRead && !legal_ld);
        do_st        = RSTn && idle && MemWrite && legal_st;
        do_ld        = idle && MemRead && !MemWrite && legal_ld;
        stall        = RSTn && (do_ld || state == RD_WAIT);
        access_fault = RSTn && fault;
        be           = funct3[1:0] == 2'b00 ? 4'b0001 << lane :
                       funct3[1:0] == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata        = funct3[1:0] == 2'b00 ? {4{write_data_DMEM[7:0]}} :
                       funct3[1:0] == 2'b01 ? {2{write_data_DMEM[15:0]}} : write_data_DMEM;
        rb           = ram_q[{lane_q, 3'b000} +: 8];
        rh           = lane_q[1] ? ram_q[31:16] : ram_q[15:0];
        ext          = f3_q[1:0] == 2'b00 ? {{24{rb[7] & !f3_q[2]}}, rb} :
                       f3_q[1:0] == 2'b01 ? {{16{rh[15] & !f3_q[2]}}, rh} : ram_q;
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++)
            if (do_st && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        if (do_ld) ram_q <= mem[idx];
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state     <= IDLE;
            data_DMEM <= '0;
            f3_q      <= '0;
            lane_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fault) data_DMEM <= '0;
                    if (do_ld) begin
                        state  <= RD_WAIT;
                        f3_q   <= funct3;
                        lane_q <= lane;
                    end
                end
                RD_WAIT: begin
                    data_DMEM <= ext;
                    state     <= RD_DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed and random loads/stores checked against a byte-addressed memory model.
module tb_dmem_lsu;
    logic        CLK = 1'b0;
    logic        RSTn;
    logic        MemRead, MemWrite;
    logic [9:0]  address_DMEM;
    logic [31:0] write_data_DMEM;
    logic [2:0]  funct3;
    logic [31:0] data_DMEM;
    logic        stall, access_fault;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [7:0]  mem_m [1024];
    logic [31:0] exp_data;

    dmem_lsu #(.ADDR_W(10), .INIT_ZERO(1'b1)) dut (
        .CLK(CLK), .RSTn(RSTn), .MemRead(MemRead), .MemWrite(MemWrite),
        .address_DMEM(address_DMEM), .write_data_DMEM(write_data_DMEM), .funct3(funct3),
        .data_DMEM(data_DMEM), .stall(stall), .access_fault(access_fault)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One core request, held for as long as the unit stalls; returns just after the core advances.
    task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [9:0] a, input logic [31:0] wd);
        int          n;
        logic        legal, ld;
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: n = 1;
            3'd1, 3'd5: n = 2;
            3'd2:       n = 4;
            default:    n = 0;
        endcase
        legal = n != 0 && (int'(a) % n) == 0 && !(wr && f3[2]);
        ld    = rd && !wr && legal;
        MemRead = rd; MemWrite = wr; funct3 = f3; address_DMEM = a; write_data_DMEM = wd;
        @(negedge CLK);
        check("fault", {31'b0, access_fault}, {31'b0, (rd || wr) && !legal});
        check("stall_req", {31'b0, stall}, {31'b0, ld});
        if (wr && legal)
            for (int i = 0; i < n; i++) mem_m[int'(a) + i] = wd[8*i +: 8];
        if (ld) begin
            v = 0;
            for (int i = 0; i < n; i++) v |= 32'(mem_m[int'(a) + i]) << (8 * i);
            if (!f3[2] && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 1);
            @(posedge CLK); #1;
            @(negedge CLK);
            check("stall_wait", {31'b0, stall}, 32'd1);
            check("fault_wait", {31'b0, access_fault}, 32'd0);
            @(posedge CLK); #1;
            @(negedge CLK);
            check("stall_done", {31'b0, stall}, 32'd0);
            check("load_data", data_DMEM, v);
            exp_data = v;
        end else if ((rd || wr) && !legal) begin
            exp_data = 0;
        end
        @(posedge CLK); #1;
        MemRead = 0; MemWrite = 0;
        check("data_hold", data_DMEM, exp_data);
    endtask

    initial begin
        logic [2:0] legal_f3 [5];
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 1024; i++) mem_m[i] = 8'h00;
        exp_data = 0;
        RSTn = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'd2;
        address_DMEM = 10'h010; write_data_DMEM = 32'h0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_fault", {31'b0, access_fault}, 32'd0);
        check("rst_data", data_DMEM, 32'd0);
        MemRead = 1'b0;
        @(posedge CLK); #1;
        RSTn = 1'b1;

        op(0, 1, 3'd2, 10'h010, 32'hDEADBEEF);
        op(1, 0, 3'd2, 10'h010, 32'h0);
        check("lw_010", data_DMEM, 32'hDEADBEEF);
        op(0, 1, 3'd0, 10'h021, 32'h00000080);
        op(0, 1, 3'd1, 10'h022, 32'h00008001);
        op(1, 0, 3'd0, 10'h021, 32'h0);
        check("lb_021", data_DMEM, 32'hFFFFFF80);
        op(1, 0, 3'd4, 10'h021, 32'h0);
        check("lbu_021", data_DMEM, 32'h00000080);
        op(1, 0, 3'd1, 10'h022, 32'h0);
        check("lh_022", data_DMEM, 32'hFFFF8001);
        op(1, 0, 3'd5, 10'h022, 32'h0);
        check("lhu_022", data_DMEM, 32'h00008001);
        op(1, 0, 3'd2, 10'h020, 32'h0);
        check("lw_020", data_DMEM, 32'h80018000);

        op(1, 0, 3'd2, 10'h013, 32'h0);
        op(0, 1, 3'd1, 10'h015, 32'h0000AAAA);
        op(1, 0, 3'd2, 10'h014, 32'h0);
        op(1, 0, 3'd6, 10'h014, 32'h0);
        op(0, 1, 3'd4, 10'h014, 32'h55);
        op(1, 0, 3'd2, 10'h014, 32'h0);

        op(1, 0, 3'd2, 10'h010, 32'h0);
        op(1, 0, 3'd2, 10'h020, 32'h0);

        op(1, 1, 3'd2, 10'h030, 32'h12345678);
        op(1, 0, 3'd2, 10'h030, 32'h0);
        check("lw_030", data_DMEM, 32'h12345678);

        MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'd2; address_DMEM = 10'h020;
        @(posedge CLK); #1;
        RSTn = 1'b0;
        @(negedge CLK);
        check("rst_mid_stall", {31'b0, stall}, 32'd0);
        check("rst_mid_fault", {31'b0, access_fault}, 32'd0);
        @(posedge CLK); #1;
        check("rst_mid_data", data_DMEM, 32'd0);
        exp_data = 0;
        MemRead = 1'b0; RSTn = 1'b1;
        @(negedge CLK);
        check("idle_after_rst", {31'b0, stall}, 32'd0);
        @(posedge CLK); #1;
        op(1, 0, 3'd2, 10'h010, 32'h0);
        check("lw_010_after_rst", data_DMEM, 32'hDEADBEEF);

        for (int k = 0; k < 120; k++) begin
            int         kind;
            logic [2:0] f3;
            logic [9:0] a;
            kind = int'($urandom_range(0, 9));
            f3   = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
            a    = 10'h040 + 10'($urandom_range(0, 31));
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            op(kind >= 4, kind < 4 || kind == 9, f3, a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit plus data memory, directly downstream of the core's data-memory port.
- Consumes address_DMEM, write_data_DMEM, MemRead and MemWrite, plus funct3 of the current instruction.
- Performs byte, half and word stores through byte enables into an internal synchronous-read RAM.
- Returns sign- or zero-extended load data and holds the core with a stall handshake while the registered RAM read completes.

Parameters:
- ADDR_W, 10, byte-address width; matches the core's 10-bit DMEM address; RAM depth is 2^(ADDR_W-2) words.
- INIT_ZERO, 1, when 1 the RAM is zeroed at time 0 for simulation; reset never clears the RAM.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RSTn  in  1  synchronous active-low reset.
- MemRead  in  1  load request from core.
- MemWrite  in  1  store request from core.
- address_DMEM  in  ADDR_W  byte address (ALU result).
- write_data_DMEM  in  32  store data; the low byte or low half is used for SB/SH.
- funct3  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- data_DMEM  out  32  extended load data, registered.
- stall  out  1  core must hold PC and all inputs stable while 1.
- access_fault  out  1  current request is misaligned or has an illegal funct3.

Behaviour:
- Reset: when RSTn=0 at a rising edge, the following apply.
  - FSM goes to IDLE.
  - data_DMEM becomes 0.
  - stall and access_fault read 0 while RSTn=0.
  - Any in-flight load is abandoned. RAM contents are kept.
- Alignment: an access is legal only if all of the following hold; otherwise access_fault=1 (combinational, in IDLE).
  - Halfword: addr[0]=0. Word: addr[1:0]=00. Byte: any address.
  - Loads accept funct3 000, 001, 010, 100 and 101. Stores accept 000, 001 and 010.
- Faulted request: no RAM access, stall=0, and data_DMEM is driven to 0 at the next edge.
- Word index is addr[ADDR_W-1:2]. Byte lane is addr[1:0].
- Stores (IDLE, MemWrite=1, legal):
  - Written on the same rising edge. No stall; latency 0 extra cycles.
  - Byte enables: SB gives 1 << addr[1:0]. SH gives 0011 (addr[1]=0) or 1100 (addr[1]=1). SW gives 1111.
  - Data is replicated to the selected lanes.
- Simultaneous MemRead and MemWrite: the store is performed, the load is ignored, and stall=0.
- FSM states:
  - IDLE:
    - MemRead=1, MemWrite=0, legal: stall=1; RAM read issued at the edge; latch funct3 and addr[1:0]; go to RD_WAIT.
    - Otherwise: stay in IDLE with stall=0.
  - RD_WAIT: the RAM word is valid this cycle. stall=1. Lane-select and extend the word, register it into data_DMEM at the edge, go to RD_DONE.
  - RD_DONE: stall=0 and data_DMEM is valid, so the core's writeback captures it at this edge. Go to IDLE unconditionally; a back-to-back load restarts from IDLE.
- Load latency: 3 cycles from request to core advance (stall high for 2 cycles).
- Extension:
  - LB and LH sign-extend bit 7 or bit 15 of the selected lane.
  - LBU and LHU zero-extend.
  - LW passes all 32 bits.
- data_DMEM holds its last value except when it is loaded in RD_WAIT or cleared by reset or a fault.
- Inputs changing while stall=1 is a core protocol violation. The latched funct3 and lane are used regardless.
- Address wrap: none. Addresses are ADDR_W bits wide and the full range maps to RAM.

Test Plan:
- Write then read word: SW 0xDEADBEEF to 0x010, then LW 0x010 → stall high for 2 cycles; data_DMEM=0xDEADBEEF in RD_DONE; access_fault=0.
- Byte and half extension:
  - Setup: SB 0x80 to 0x021, SH 0x8001 to 0x022.
  - LB 0x021 → 0xFFFFFF80. LBU 0x021 → 0x00000080. LH 0x022 → 0xFFFF8001. LHU 0x022 → 0x00008001.
  - LW 0x020 → 0x80018000 when byte 0 was previously 0x00.
- Misalignment:
  - LW 0x013 → access_fault=1, stall=0, data_DMEM=0 next cycle, no state change.
  - SH 0x015 → access_fault=1 and RAM word 0x014 unchanged.
- Back-to-back loads: LW 0x010 immediately followed by LW 0x020 → each takes 3 cycles, the FSM returns through IDLE between them, and both values are correct.
- Reset mid-load: assert RSTn=0 during RD_WAIT → next edge gives FSM IDLE, stall=0, data_DMEM=0; a following LW 0x010 still returns 0xDEADBEEF.
- Simultaneous MemRead=MemWrite=1 with SW 0x12345678 at 0x030 → no stall and the store commits; a later LW 0x030 returns 0x12345678.
